// File: rtl/ro_puf_controller_if.sv
// Host-side handshake for the RO PUF sequencer: request/challenge in, busy/done/response out.
interface ro_puf_controller_if #(
  parameter int SEL_W     = 4,
  parameter int RESP_BITS = 8
);
  logic                         start;
  logic [RESP_BITS*2*SEL_W-1:0] challenge;
  logic                         busy;
  logic                         done;
  logic [RESP_BITS-1:0]         response;
  logic [RESP_BITS-1:0]         err_flags;

  modport master (
    output start, challenge,
    input  busy, done, response, err_flags
  );

  modport slave (
    input  start, challenge,
    output busy, done, response, err_flags
  );
endinterface

// File: rtl/ro_puf_controller.sv
// Ring-oscillator PUF sequencer: per challenge slot, enable one RO pair, settle, gate the
// edge counters for a fixed window, compare the counts and record one response bit.
module ro_puf_controller #(
  parameter int NUM_RO    = 16,
  parameter int SEL_W     = 4,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 8,
  parameter int RESP_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  ro_puf_controller_if.slave host,
  output logic [NUM_RO-1:0] ro_en,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic              cnt_clr,
  output logic              cnt_en,
  input  logic [CNT_W-1:0]  cnt_a,
  input  logic [CNT_W-1:0]  cnt_b
);

  localparam int CHAL_W = RESP_BITS * 2 * SEL_W;
  localparam int K_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int T_MAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W  = $clog2(T_MAX + 1);
  localparam logic [K_W-1:0] LAST_K = K_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SETTLE,
    S_COUNT,
    S_HOLD,
    S_COMPARE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                state_reg;
  logic [CHAL_W-1:0]     chal_reg;
  logic [K_W-1:0]        k_reg;
  logic [TMR_W-1:0]      tmr_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [RESP_BITS-1:0]  resp_reg;
  logic [RESP_BITS-1:0]  err_reg;
  logic [NUM_RO-1:0]     ro_en_reg;
  logic [SEL_W-1:0]      sel_a_reg;
  logic [SEL_W-1:0]      sel_b_reg;
  logic                  cnt_clr_reg;
  logic                  cnt_en_reg;

  // Slot about to be loaded into SETUP: slot 0 straight from the input at accept,
  // otherwise slot k+1 of the latched challenge.
  logic [CHAL_W-1:0]     slot_src;
  logic [K_W-1:0]        slot_idx;
  logic [2*SEL_W-1:0]    slot_next;
  logic [SEL_W-1:0]      next_a;
  logic [SEL_W-1:0]      next_b;
  logic                  next_valid;

  always_comb begin
    slot_src   = (state_reg == S_IDLE) ? host.challenge : chal_reg;
    slot_idx   = (state_reg == S_IDLE) ? '0 : k_reg + K_W'(1);
    slot_next  = slot_src[int'(slot_idx) * (2 * SEL_W) +: 2 * SEL_W];
    next_a     = slot_next[2*SEL_W-1:SEL_W];
    next_b     = slot_next[SEL_W-1:0];
    next_valid = (next_a != next_b)
              && (32'(next_a) < 32'(NUM_RO))
              && (32'(next_b) < 32'(NUM_RO));
  end

  // Pair decode from the registered selects; only used once the slot is known valid.
  logic [NUM_RO-1:0] pair_dec;

  for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_pair_dec
    assign pair_dec[gi] = (sel_a_reg == SEL_W'(gi)) || (sel_b_reg == SEL_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      chal_reg    <= '0;
      k_reg       <= '0;
      tmr_reg     <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      resp_reg    <= '0;
      err_reg     <= '0;
      ro_en_reg   <= '0;
      sel_a_reg   <= '0;
      sel_b_reg   <= '0;
      cnt_clr_reg <= 1'b1;
      cnt_en_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (host.start) begin
            chal_reg  <= host.challenge;
            k_reg     <= '0;
            resp_reg  <= '0;
            err_reg   <= '0;
            busy_reg  <= 1'b1;
            sel_a_reg <= next_a;
            sel_b_reg <= next_b;
            valid_reg <= next_valid;
            state_reg <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (valid_reg) begin
            ro_en_reg <= pair_dec;
            tmr_reg   <= TMR_W'(SETTLE - 1);
            state_reg <= S_SETTLE;
          end else begin
            err_reg[k_reg]  <= 1'b1;
            resp_reg[k_reg] <= 1'b0;
            cnt_clr_reg     <= 1'b0;
            state_reg       <= S_NEXT;
          end
        end

        S_SETTLE: begin
          if (tmr_reg == '0) begin
            cnt_clr_reg <= 1'b0;
            cnt_en_reg  <= 1'b1;
            tmr_reg     <= TMR_W'(WINDOW - 1);
            state_reg   <= S_COUNT;
          end else begin
            tmr_reg <= tmr_reg - TMR_W'(1);
          end
        end

        S_COUNT: begin
          if (tmr_reg == '0) begin
            cnt_en_reg <= 1'b0;
            tmr_reg    <= TMR_W'(1);
            state_reg  <= S_HOLD;
          end else begin
            tmr_reg <= tmr_reg - TMR_W'(1);
          end
        end

        // Two idle cycles let the last edges ripple through the counter synchronizers.
        S_HOLD: begin
          if (tmr_reg == '0) begin
            ro_en_reg <= '0;
            state_reg <= S_COMPARE;
          end else begin
            tmr_reg <= tmr_reg - TMR_W'(1);
          end
        end

        S_COMPARE: begin
          resp_reg[k_reg] <= (cnt_a > cnt_b);
          err_reg[k_reg]  <= (cnt_a == cnt_b);
          state_reg       <= S_NEXT;
        end

        S_NEXT: begin
          cnt_clr_reg <= 1'b1;
          if (k_reg == LAST_K) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_DONE;
          end else begin
            k_reg     <= k_reg + K_W'(1);
            sel_a_reg <= next_a;
            sel_b_reg <= next_b;
            valid_reg <= next_valid;
            state_reg <= S_SETUP;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign host.busy      = busy_reg;
  assign host.done      = done_reg;
  assign host.response  = resp_reg;
  assign host.err_flags = err_reg;
  assign ro_en          = ro_en_reg;
  assign sel_a          = sel_a_reg;
  assign sel_b          = sel_b_reg;
  assign cnt_clr        = cnt_clr_reg;
  assign cnt_en         = cnt_en_reg;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: per-RO rate counter model, timeline model of expected outputs,
// and directed challenges with hand-computed responses and latencies.
module tb_ro_puf_controller;

  localparam int NUM_RO    = 16;
  localparam int SEL_W     = 4;
  localparam int CNT_W     = 16;
  localparam int WINDOW    = 16;
  localparam int SETTLE    = 2;
  localparam int RESP_BITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ro_puf_controller_if #(.SEL_W(SEL_W), .RESP_BITS(RESP_BITS)) host ();

  logic [NUM_RO-1:0] ro_en;
  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              cnt_clr, cnt_en;
  logic [CNT_W-1:0]  cnt_a = '0, cnt_b = '0, raw_a = '0, raw_b = '0;

  ro_puf_controller #(
    .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W),
    .WINDOW(WINDOW), .SETTLE(SETTLE), .RESP_BITS(RESP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .host(host),
    .ro_en(ro_en), .sel_a(sel_a), .sel_b(sel_b),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  int tests = 0;
  int fails = 0;
  int done_count = 0;
  int rate [NUM_RO];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edge counters: each counts its selected RO's edges (rate per clk) while enabled,
  // followed by one synchronizer stage.
  always @(posedge clk) begin
    if (cnt_clr) begin
      raw_a <= '0;
      raw_b <= '0;
    end else if (cnt_en) begin
      if (ro_en[sel_a]) raw_a <= raw_a + CNT_W'(rate[sel_a]);
      if (ro_en[sel_b]) raw_b <= raw_b + CNT_W'(rate[sel_b]);
    end
    cnt_a <= raw_a;
    cnt_b <= raw_b;
  end

  // Expected per-cycle output timeline, expanded from the slot list at each accepted start.
  typedef struct packed {
    logic              busy;
    logic              done;
    logic [NUM_RO-1:0] ro_en;
    logic [SEL_W-1:0]  sa;
    logic [SEL_W-1:0]  sb;
    logic              en;
    logic              clr;
  } exp_t;

  exp_t q[$];
  logic [RESP_BITS-1:0] held_resp = '0, held_err = '0;
  logic [SEL_W-1:0]     held_a = '0, held_b = '0;

  function automatic exp_t mk(input logic b, input logic d, input logic [NUM_RO-1:0] r,
                              input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] bb,
                              input logic e, input logic c);
    return exp_t'({b, d, r, a, bb, e, c});
  endfunction

  task automatic build(input logic [31:0] chal);
    logic [SEL_W-1:0]  a, b;
    logic [NUM_RO-1:0] pair;
    int ca, cb;
    a = '0;
    b = '0;
    held_resp = '0;
    held_err  = '0;
    for (int k = 0; k < RESP_BITS; k++) begin
      a = chal[k*8+4 +: 4];
      b = chal[k*8 +: 4];
      q.push_back(mk(1'b1, 1'b0, '0, a, b, 1'b0, 1'b1));
      if (a != b) begin
        pair = (16'd1 << a) | (16'd1 << b);
        repeat (SETTLE) q.push_back(mk(1'b1, 1'b0, pair, a, b, 1'b0, 1'b1));
        repeat (WINDOW) q.push_back(mk(1'b1, 1'b0, pair, a, b, 1'b1, 1'b0));
        repeat (2)      q.push_back(mk(1'b1, 1'b0, pair, a, b, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 1'b0, '0, a, b, 1'b0, 1'b0));
        ca = (rate[a] * WINDOW) % 65536;
        cb = (rate[b] * WINDOW) % 65536;
        if (ca > cb) held_resp[k] = 1'b1;
        else if (ca == cb) held_err[k] = 1'b1;
      end else begin
        held_err[k] = 1'b1;
      end
      q.push_back(mk(1'b1, 1'b0, '0, a, b, 1'b0, 1'b0));
    end
    q.push_back(mk(1'b0, 1'b1, '0, a, b, 1'b0, 1'b1));
    held_a = a;
    held_b = b;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      held_resp = '0;
      held_err  = '0;
      held_a    = '0;
      held_b    = '0;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (host.start) begin
      build(host.challenge);
    end
  end

  exp_t exp_now, act_now;
  int   en_run = 0;

  always @(negedge clk) begin
    act_now = exp_t'({host.busy, host.done, ro_en, sel_a, sel_b, cnt_en, cnt_clr});
    exp_now = (q.size() > 0) ? q[0] : mk(1'b0, 1'b0, '0, held_a, held_b, 1'b0, 1'b1);
    check("cycle", 64'(act_now), 64'(exp_now));
    if (!exp_now.busy) begin
      check("response", 64'(host.response), 64'(held_resp));
      check("err_flags", 64'(host.err_flags), 64'(held_err));
    end
    check("ro_en_popcount", 64'($countones(ro_en) <= 2), 64'(1));
    check("done_with_busy", 64'(host.done & host.busy), 64'(0));
    if (rst) begin
      en_run = 0;
    end else if (cnt_en) begin
      en_run++;
    end else if (en_run > 0) begin
      check("cnt_en_window", 64'(en_run), 64'(WINDOW));
      en_run = 0;
    end
    if (host.done) done_count++;
  end

  task automatic run(input logic [31:0] chal, input int exp_lat, input logic [3:0] exp_resp,
                     input logic [3:0] exp_err, input string name, input int disturb);
    int n;
    host.challenge = chal;
    host.start     = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    n = 1;
    while (!host.done && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == disturb) begin
        host.start     = 1'b1;
        host.challenge = 32'h55555555;
      end else if (n == disturb + 1) begin
        host.start = 1'b0;
      end
    end
    if (!host.done) begin
      check({name, "_timeout"}, 64'(0), 64'(1));
    end else begin
      check({name, "_latency"}, 64'(n), 64'(exp_lat));
      check({name, "_response"}, 64'(host.response), 64'(exp_resp));
      check({name, "_err_flags"}, 64'(host.err_flags), 64'(exp_err));
    end
    $display("[TB] %s chal=%h latency=%0d response=%b err_flags=%b", name, chal, n,
             host.response, host.err_flags);
    @(negedge clk);
  endtask

  initial begin
    int d0, rises, n;
    logic prev;
    for (int i = 0; i < NUM_RO; i++) rate[i] = 1;
    rate[2] = 5;
    rate[3] = 5;
    rate[7] = 3;
    host.start     = 1'b0;
    host.challenge = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(host.busy), 64'(0));
    check("rst_cnt_clr", 64'(cnt_clr), 64'(1));
    check("rst_ro_en", 64'(ro_en), 64'(0));
    check("rst_response", 64'(host.response), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run(32'h37373737, 93, 4'b1111, 4'b0000, "t1_all_37", 0);
    run(32'h37733773, 93, 4'b1010, 4'b0000, "t2_alternate", 0);
    run(32'h73372355, 72, 4'b0100, 4'b0011, "t3_invalid_tie", 0);

    d0 = done_count;
    run(32'h37737337, 93, 4'b1001, 4'b0000, "t4_ignore_start", 30);
    repeat (3) @(negedge clk);
    check("t4_done_pulses", 64'(done_count - d0), 64'(1));

    host.challenge = 32'h37373737;
    host.start     = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    rises = 0;
    prev  = 1'b0;
    n     = 0;
    while (rises < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (cnt_en && !prev) rises++;
      prev = cnt_en;
    end
    check("t5_reach_slot2", 64'(rises), 64'(3));
    repeat (5) @(negedge clk);
    check("t5_pre_rst_response", 64'(host.response), 64'(4'b0011));
    rst = 1'b1;
    @(negedge clk);
    check("t5_ro_en", 64'(ro_en), 64'(0));
    check("t5_cnt_en", 64'(cnt_en), 64'(0));
    check("t5_cnt_clr", 64'(cnt_clr), 64'(1));
    check("t5_busy", 64'(host.busy), 64'(0));
    check("t5_response", 64'(host.response), 64'(0));
    $display("[TB] t5_reset_mid_count ro_en=%h cnt_en=%b busy=%b response=%b",
             ro_en, cnt_en, host.busy, host.response);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(32'h37373737, 93, 4'b1111, 4'b0000, "t5_fresh", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
